// File: rtl/integration_sequencer.sv
// Frame sequencer for the lag correlator array. Each frame clears, integrates, settles,
// then holds the frozen frame for readout. Every output comes straight from a register.
module integration_sequencer #(
    parameter int TIME_WIDTH    = 24,
    parameter int CLEAR_CYCLES  = 2,
    parameter int SETTLE_CYCLES = 4,
    parameter int TIMEOUT_WIDTH = 20,
    parameter int MAX_ORDER     = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  stop,
    input  logic [TIME_WIDTH-1:0] integration_time,
    input  logic [7:0]            order_in,
    output logic                  corr_enable,
    output logic                  corr_clear,
    output logic [7:0]            order_out,
    output logic                  frame_valid,
    input  logic                  frame_ready,
    output logic                  busy,
    output logic                  overrun,
    output logic [15:0]           frame_count
);

    localparam int CLR_W = $clog2(CLEAR_CYCLES + 1);
    localparam int SET_W = $clog2(SETTLE_CYCLES + 1);
    localparam int PHASE_W = (CLR_W > SET_W) ? CLR_W : SET_W;
    localparam int CNT_W = (TIME_WIDTH > PHASE_W) ? TIME_WIDTH : PHASE_W;
    localparam logic [CNT_W-1:0] CLR_LOAD = CNT_W'(CLEAR_CYCLES - 1);
    localparam logic [CNT_W-1:0] SET_LOAD = CNT_W'(SETTLE_CYCLES - 1);
    // Last readout cycle count before giving up: the counter would reach all-ones next.
    localparam logic [TIMEOUT_WIDTH-1:0] TMO_LAST = {{(TIMEOUT_WIDTH-1){1'b1}}, 1'b0};
    localparam logic [7:0] ORDER_MAX = 8'(MAX_ORDER);

    typedef enum logic [2:0] {IDLE, CLEAR, INTEGRATE, SETTLE, READOUT} state_t;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [TIMEOUT_WIDTH-1:0] tmo_q, tmo_d;
    logic [TIME_WIDTH-1:0]   t_len_q, t_len_d;
    logic [7:0]              order_q, order_d;
    logic                    stop_pending_q, stop_pending_d;
    logic                    overrun_q, overrun_d;
    logic [15:0]             frame_count_q, frame_count_d;
    logic                    corr_enable_q, corr_enable_d;
    logic                    corr_clear_q, corr_clear_d;
    logic                    frame_valid_q, frame_valid_d;
    logic                    busy_q, busy_d;
    logic                    frame_end;
    logic                    latch_frame;
    logic                    stopping;

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        tmo_d          = tmo_q;
        t_len_d        = t_len_q;
        order_d        = order_q;
        stop_pending_d = stop_pending_q;
        overrun_d      = overrun_q;
        frame_count_d  = frame_count_q;
        frame_end      = 1'b0;
        latch_frame    = 1'b0;
        stopping       = stop_pending_q | stop;

        if (state_q != IDLE && stop) begin
            stop_pending_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (start && !stop) begin
                    latch_frame = 1'b1;
                    overrun_d   = 1'b0;
                end
            end
            CLEAR: begin
                if (cnt_q == '0) begin
                    state_d = INTEGRATE;
                    cnt_d   = CNT_W'(t_len_q - TIME_WIDTH'(1));
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            INTEGRATE: begin
                if (cnt_q == '0) begin
                    state_d = SETTLE;
                    cnt_d   = SET_LOAD;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            SETTLE: begin
                if (cnt_q == '0) begin
                    state_d = READOUT;
                    tmo_d   = '0;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            READOUT: begin
                // frame_valid is always high here, so ready alone completes the handshake.
                if (frame_ready) begin
                    frame_count_d = frame_count_q + 16'd1;
                    frame_end     = 1'b1;
                end else if (tmo_q == TMO_LAST) begin
                    overrun_d = 1'b1;
                    frame_end = 1'b1;
                end else begin
                    tmo_d = tmo_q + TIMEOUT_WIDTH'(1);
                end
                if (frame_end) begin
                    if (stopping) begin
                        state_d        = IDLE;
                        stop_pending_d = 1'b0;
                    end else begin
                        latch_frame = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (latch_frame) begin
            t_len_d = (integration_time == '0) ? TIME_WIDTH'(1) : integration_time;
            order_d = (order_in > ORDER_MAX) ? ORDER_MAX : order_in;
            state_d = CLEAR;
            cnt_d   = CLR_LOAD;
        end

        // Outputs are registered from the next state so they line up with it.
        corr_enable_d = (state_d == CLEAR) || (state_d == INTEGRATE);
        corr_clear_d  = (state_d == CLEAR);
        frame_valid_d = (state_d == READOUT);
        busy_d        = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            tmo_q          <= '0;
            t_len_q        <= '0;
            order_q        <= '0;
            stop_pending_q <= 1'b0;
            overrun_q      <= 1'b0;
            frame_count_q  <= '0;
            corr_enable_q  <= 1'b0;
            corr_clear_q   <= 1'b0;
            frame_valid_q  <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            tmo_q          <= tmo_d;
            t_len_q        <= t_len_d;
            order_q        <= order_d;
            stop_pending_q <= stop_pending_d;
            overrun_q      <= overrun_d;
            frame_count_q  <= frame_count_d;
            corr_enable_q  <= corr_enable_d;
            corr_clear_q   <= corr_clear_d;
            frame_valid_q  <= frame_valid_d;
            busy_q         <= busy_d;
        end
    end

    assign corr_enable = corr_enable_q;
    assign corr_clear  = corr_clear_q;
    assign order_out   = order_q;
    assign frame_valid = frame_valid_q;
    assign busy        = busy_q;
    assign overrun     = overrun_q;
    assign frame_count = frame_count_q;

endmodule

// File: tb/tb_integration_sequencer.sv
// Bench for integration_sequencer: frame-timeline reference model, per-cycle output checks
// and a per-frame scoreboard popped whenever the DUT raises frame_valid.
module tb_integration_sequencer;

    localparam int TW      = 24;
    localparam int CLR     = 2;
    localparam int SET     = 4;
    localparam int TMOW    = 4;
    localparam int MAXO    = 2;
    localparam int TMO_CYC = (1 << TMOW) - 1;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          stop;
    logic [TW-1:0] integration_time;
    logic [7:0]    order_in;
    logic          frame_ready;
    logic          corr_enable;
    logic          corr_clear;
    logic [7:0]    order_out;
    logic          frame_valid;
    logic          busy;
    logic          overrun;
    logic [15:0]   frame_count;

    always #5 clk = ~clk;

    integration_sequencer #(
        .TIME_WIDTH(TW), .CLEAR_CYCLES(CLR), .SETTLE_CYCLES(SET),
        .TIMEOUT_WIDTH(TMOW), .MAX_ORDER(MAXO)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .stop(stop),
        .integration_time(integration_time), .order_in(order_in),
        .corr_enable(corr_enable), .corr_clear(corr_clear), .order_out(order_out),
        .frame_valid(frame_valid), .frame_ready(frame_ready), .busy(busy),
        .overrun(overrun), .frame_count(frame_count)
    );

    typedef struct {
        int ord;
        int tlen;
        int cnt;
    } frame_t;

    frame_t exp_q[$];
    int n_vec = 0;
    int n_err = 0;

    // Reference model: a frame is a timeline measured by offset from its first clear cycle.
    bit m_run, m_pend, m_ovr;
    int m_off, m_tlen, m_ord, m_cnt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s at %0t: actual=%0d required=%0d", name, $time, act, req);
        end
    endtask

    function automatic void model_frame();
        m_tlen = (integration_time == '0) ? 1 : int'(integration_time);
        m_ord  = (int'(order_in) > MAXO) ? MAXO : int'(order_in);
        m_off  = 0;
        m_run  = 1'b1;
        exp_q.push_back('{m_ord, m_tlen, m_cnt});
    endfunction

    initial begin
        int  ro;
        bit  done;
        m_run = 0; m_pend = 0; m_ovr = 0; m_off = 0; m_tlen = 1; m_ord = 0; m_cnt = 0;
        forever begin
            @(posedge clk or posedge reset);
            if (reset) begin
                m_run = 0; m_pend = 0; m_ovr = 0; m_off = 0; m_tlen = 1; m_ord = 0; m_cnt = 0;
                exp_q.delete();
            end else if (!m_run) begin
                if (start && !stop) begin
                    m_ovr = 0;
                    model_frame();
                end
            end else begin
                if (stop) m_pend = 1;
                ro   = CLR + m_tlen + SET;
                done = 0;
                if (m_off >= ro) begin
                    if (frame_ready) begin
                        m_cnt = (m_cnt + 1) % 65536;
                        done  = 1;
                    end else if (m_off - ro == TMO_CYC - 1) begin
                        m_ovr = 1;
                        done  = 1;
                    end
                end
                if (!done) m_off++;
                else if (m_pend) begin
                    m_run  = 0;
                    m_pend = 0;
                end else model_frame();
            end
        end
    end

    // Monitor: per-cycle comparison plus a scoreboard pop on each new frame_valid.
    initial begin
        int     mc_clr = 0;
        int     mc_en = 0;
        int     mc_set = 0;
        bit     pv = 0;
        frame_t f;
        forever begin
            @(negedge clk);
            chk("busy", 32'(busy), 32'(m_run));
            chk("corr_enable", 32'(corr_enable), 32'(m_run && m_off < CLR + m_tlen));
            chk("corr_clear", 32'(corr_clear), 32'(m_run && m_off < CLR));
            chk("frame_valid", 32'(frame_valid), 32'(m_run && m_off >= CLR + m_tlen + SET));
            chk("order_out", 32'(order_out), 32'(m_ord));
            chk("overrun", 32'(overrun), 32'(m_ovr));
            chk("frame_count", 32'(frame_count), 32'(m_cnt));
            if (reset) begin
                mc_clr = 0; mc_en = 0; mc_set = 0; pv = 0;
            end else begin
                if (corr_clear) mc_clr++;
                if (corr_enable) mc_en++;
                if (busy && !corr_enable && !frame_valid) mc_set++;
                if (frame_valid && !pv) begin
                    if (exp_q.size() == 0) begin
                        chk("sb_pending", 32'(exp_q.size()), 32'd1);
                    end else begin
                        f = exp_q.pop_front();
                        chk("sb_order", 32'(order_out), 32'(f.ord));
                        chk("sb_clear_cycles", 32'(mc_clr), 32'(CLR));
                        chk("sb_enable_cycles", 32'(mc_en), 32'(CLR + f.tlen));
                        chk("sb_settle_cycles", 32'(mc_set), 32'(SET));
                        chk("sb_count", 32'(frame_count), 32'(f.cnt));
                    end
                    mc_clr = 0; mc_en = 0; mc_set = 0;
                end
                pv = frame_valid;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_rst();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1;
        tick();
        stop = 1'b0;
    endtask

    task automatic wait_count(input int target, input int limit);
        int n = 0;
        while (int'(frame_count) != target && n < limit) begin
            tick();
            n++;
        end
        chk("wait_count", 32'(frame_count), 32'(target));
    endtask

    task automatic wait_idle(input int limit);
        int n = 0;
        while (busy && n < limit) begin
            tick();
            n++;
        end
        chk("wait_idle", 32'(busy), 32'd0);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; stop = 1'b0; frame_ready = 1'b1;
        integration_time = 24'd10; order_in = 8'd1;
        repeat (3) @(posedge clk);
        #3 reset = 1'b0;
        tick();
        chk("rst_frame_count", 32'(frame_count), 32'd0);
        chk("rst_order_out", 32'(order_out), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);

        // Nominal framing with ready tied high.
        pulse_start();
        wait_count(2, 100);
        pulse_stop();
        wait_idle(100);

        // Order clamp, and mid-frame input changes deferred to the next frame.
        apply_rst();
        order_in = 8'd7;
        pulse_start();
        repeat (4) tick();
        chk("order_clamped", 32'(order_out), 32'd2);
        order_in = 8'd0;
        repeat (3) tick();
        chk("order_held", 32'(order_out), 32'd2);
        wait_count(1, 100);
        chk("order_relatched", 32'(order_out), 32'd0);
        pulse_stop();
        wait_idle(100);

        // Stop during the integration of frame 3.
        apply_rst();
        integration_time = 24'd3; order_in = 8'd1;
        pulse_start();
        wait_count(2, 100);
        repeat (3) tick();
        pulse_stop();
        wait_idle(100);
        chk("stop_count", 32'(frame_count), 32'd3);
        repeat (8) tick();
        chk("stop_no_enable", 32'(corr_enable), 32'd0);

        // Readout timeout sets overrun and restarts; the next start clears it.
        apply_rst();
        integration_time = 24'd2; frame_ready = 1'b0;
        pulse_start();
        begin
            int n = 0;
            while (!overrun && n < 100) begin
                tick();
                n++;
            end
        end
        chk("tmo_overrun", 32'(overrun), 32'd1);
        chk("tmo_count", 32'(frame_count), 32'd0);
        chk("tmo_reclear", 32'(corr_clear), 32'd1);
        pulse_stop();
        frame_ready = 1'b1;
        wait_idle(100);
        chk("tmo_sticky", 32'(overrun), 32'd1);
        pulse_start();
        chk("tmo_cleared", 32'(overrun), 32'd0);
        pulse_stop();
        wait_idle(100);

        // Asynchronous reset between clock edges while integrating.
        apply_rst();
        integration_time = 24'd20;
        pulse_start();
        wait_count(1, 100);
        repeat (6) tick();
        #3 reset = 1'b1;
        #1;
        chk("async_enable", 32'(corr_enable), 32'd0);
        chk("async_busy", 32'(busy), 32'd0);
        chk("async_count", 32'(frame_count), 32'd0);
        tick();
        #3 reset = 1'b0;
        repeat (10) tick();
        chk("async_stays_idle", 32'(busy), 32'd0);

        // Zero integration length, and start+stop together in IDLE.
        integration_time = 24'd0;
        pulse_start();
        wait_count(1, 100);
        pulse_stop();
        wait_idle(100);
        start = 1'b1; stop = 1'b1;
        tick();
        start = 1'b0; stop = 1'b0;
        repeat (5) tick();
        chk("start_stop_idle", 32'(busy), 32'd0);

        // Randomized traffic with stall bursts and occasional mid-cycle resets.
        apply_rst();
        for (int i = 0; i < 3000; i++) begin
            start = ($urandom_range(0, 19) == 0);
            stop  = ($urandom_range(0, 59) == 0);
            if ($urandom_range(0, 7) == 0) integration_time = TW'($urandom_range(0, 12));
            if ($urandom_range(0, 9) == 0) order_in = 8'($urandom_range(0, 255));
            frame_ready = (i % 400 < 25) ? 1'b0 : ($urandom_range(0, 3) != 0);
            tick();
            if (i % 1100 == 700) begin
                #3 reset = 1'b1;
                @(posedge clk);
                #3 reset = 1'b0;
            end
        end
        start = 1'b0; frame_ready = 1'b1;
        pulse_stop();
        wait_idle(200);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/integration_sequencer.md
Name: integration_sequencer

Overview:
- Frame-level controller for the lag correlator array.
- Runs a repeating cycle: clear accumulators, integrate for a programmed number of clk cycles, freeze, hand the frozen frame to the readout/serializer, repeat.
- Drives the correlator's enable, clear and order inputs; gives the UART/packetizer a valid/ready frame handshake.
- Sits between the host command decoder and the correlator core.

Parameters:
- TIME_WIDTH, 24, width of the integration-length counter in clk cycles.
- CLEAR_CYCLES, 2, cycles corr_clear is held high at the start of each frame (at least 1).
- SETTLE_CYCLES, 4, cycles with enable low after integration so delay lines and accumulators stop before readout (at least 1).
- TIMEOUT_WIDTH, 20, width of the readout timeout counter; timeout is 2^TIMEOUT_WIDTH-1 cycles.
- MAX_ORDER, 2, highest correlation order accepted; larger requests are clamped.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  single-cycle pulse: begin continuous framing
- stop  in  1  single-cycle pulse: finish current frame then halt
- integration_time  in  TIME_WIDTH  integration length in cycles; sampled at each frame start
- order_in  in  8  requested correlation order; sampled at each frame start
- corr_enable  out  1  correlator enable
- corr_clear  out  1  correlator accumulator clear (correlator reset input)
- order_out  out  8  order applied to the correlator for the current frame
- frame_valid  out  1  frozen frame available to readout
- frame_ready  in  1  readout accepts the frame
- busy  out  1  high in any state other than IDLE
- overrun  out  1  sticky: a frame was dropped on readout timeout
- frame_count  out  16  frames handed off (valid and ready both high), wraps at 0xFFFF to 0

Behaviour:
- Reset (asynchronous, immediate, any state):
  - state goes to IDLE.
  - All outputs go to 0, including order_out, overrun and frame_count.
  - stop_pending and the internal counters clear.
  - A frame in progress is abandoned and no handshake completes.
- All other logic is synchronous to the rising edge of clk.
- IDLE:
  - corr_enable = corr_clear = frame_valid = busy = 0.
  - start=1 with stop=0: latch integration_time into t_len (0 is treated as 1), latch min(order_in, MAX_ORDER) into order_out, clear overrun, go to CLEAR.
  - start and stop high together: stay in IDLE.
  - stop alone: ignored.
- CLEAR:
  - corr_enable=1 and corr_clear=1 for exactly CLEAR_CYCLES cycles (the correlator clears only while enabled).
  - Then go to INTEGRATE with the down-counter loaded with t_len.
- INTEGRATE:
  - corr_enable=1, corr_clear=0 for exactly t_len cycles, then go to SETTLE.
  - integration_time and order_in changes during this state have no effect until the next CLEAR entry.
- SETTLE:
  - corr_enable=0 for exactly SETTLE_CYCLES cycles, then go to READOUT with the timeout counter at 0.
- READOUT:
  - corr_enable=0; frame_valid=1 from the first READOUT cycle.
  - On a cycle with frame_valid and frame_ready both high: frame_count increments, frame_valid drops on the next cycle.
    - If stop_pending is set: go to IDLE and clear stop_pending.
    - Otherwise: re-latch t_len and order_out from the inputs and go to CLEAR.
  - frame_ready while frame_valid=0 is ignored.
  - The timeout counter increments each cycle without a handshake. At 2^TIMEOUT_WIDTH-1:
    - overrun is set and frame_count is not incremented.
    - frame_valid drops and the next state follows the same stop_pending rule.
- stop_pending:
  - Set by stop in any non-IDLE state; stays set until consumed at the end of READOUT or cleared by reset.
  - A start pulse while busy is ignored.
- Latency:
  - start to first corr_clear: 1 cycle.
  - Frame period with an immediate ready: CLEAR_CYCLES + t_len + SETTLE_CYCLES + 1 cycles.
- corr_enable and corr_clear come straight from registers: no combinational path from inputs to outputs.

Test Plan:
- Defaults, integration_time=10, order_in=1, frame_ready tied high, pulse start at cycle 0:
  - corr_clear high cycles 1-2; corr_enable high cycles 1-12, low cycles 13-16.
  - frame_valid high cycle 17; frame_count=1 at cycle 18; next corr_clear at cycle 18.
- order_in=7 at start: order_out=2. Change order_in to 0 mid-INTEGRATE: order_out stays 2 until the next CLEAR, then becomes 0.
- Pulse stop during INTEGRATE of frame 3: frame 3 completes its handshake, frame_count=3, then IDLE with busy=0 and no further corr_enable.
- frame_ready held low, TIMEOUT_WIDTH=4: after 15 READOUT cycles, overrun=1, frame_count unchanged, sequencer re-enters CLEAR; the next start clears overrun.
- Assert reset asynchronously mid-INTEGRATE (between clock edges): corr_enable, busy and frame_count drop to 0 immediately; after reset releases, stays IDLE until start.
- integration_time=0: INTEGRATE lasts exactly 1 cycle. start and stop pulsed together in IDLE: no activity, busy stays 0.
